// File: rtl/data_mem_responder.sv
// Memory-side responder for the multicycle RV32I core: one load/store at a time,
// byte-lane stores, funct3-formatted loads and a fixed number of wait states.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT   = 4'(LATENCY);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  funct3_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic        accept, commit, do_write;
  logic [31:0] cur_addr, cur_wdata, shifted;
  logic [3:0]  cur_wstrb;
  logic [2:0]  cur_funct3;
  logic [AW-1:0] cur_idx;
  logic        range_err, fmt_err;

  // FSM next state; commit marks the edge that enters RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LAT == 4'd0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero latency the commit happens in IDLE, before the capture registers load.
  always_comb begin
    cur_addr   = (state_q == S_IDLE) ? req_addr   : addr_q;
    cur_wstrb  = (state_q == S_IDLE) ? req_wstrb  : wstrb_q;
    cur_wdata  = (state_q == S_IDLE) ? req_wdata  : wdata_q;
    cur_funct3 = (state_q == S_IDLE) ? req_funct3 : funct3_q;
    cur_idx    = cur_addr[2 +: AW];
    range_err  = {1'b0, cur_addr} >= LIMIT;
    shifted    = mem_q[cur_idx] >> {cur_addr[1:0], 3'b000};
    fmt_err    = 1'b0;
    rdata_d    = 32'd0;
    unique case (cur_funct3)
      3'b000: rdata_d = {{24{shifted[7]}}, shifted[7:0]};
      3'b100: rdata_d = {24'd0, shifted[7:0]};
      3'b001: begin
        rdata_d = {{16{shifted[15]}}, shifted[15:0]};
        fmt_err = cur_addr[0];
      end
      3'b101: begin
        rdata_d = {16'd0, shifted[15:0]};
        fmt_err = cur_addr[0];
      end
      3'b010: begin
        rdata_d = shifted;
        fmt_err = (cur_addr[1:0] != 2'b00);
      end
      default: fmt_err = 1'b1;
    endcase
    if (cur_wstrb != 4'b0000) begin
      err_d   = range_err;
      rdata_d = 32'd0;
    end else begin
      err_d = range_err | fmt_err;
      if (err_d) rdata_d = 32'd0;
    end
    do_write = commit && !range_err && (cur_wstrb != 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      addr_q   <= req_addr;
      wstrb_q  <= req_wstrb;
      wdata_q  <= req_wdata;
      funct3_q <= req_funct3;
    end
  end

  // NOTE: the RAM array has no reset; a reset port on it would block RAM inference.
  always_ff @(posedge clk) begin
    if (do_write && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_wstrb[i]) mem_q[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the multicycle RV32I core. It accepts one load or store request at a time from the core's memory port, applies byte-lane write strobes, and returns load data formatted per `funct3` (sign/zero extended). A programmable wait-state count models slow memory. The block sits between the core's address/data mux and a word-addressed RAM array held internally.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: RAM size in 32-bit words; must be a power of two.
- `LATENCY`, default 2: wait states between request acceptance and response; legal range is 0–15.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  a request is present.
- `req_ready`  out  1  responder can accept a request.
- `req_addr`  in  32  byte address.
- `req_wstrb`  in  4  byte-lane write enables, already positioned by the core; `4'b0000` means read.
- `req_wdata`  in  32  store data, lane-aligned.
- `req_funct3`  in  3  load format; ignored for writes.
- `rsp_valid`  out  1  one-cycle pulse: response is valid.
- `rsp_rdata`  out  32  formatted load data; 0 for writes and errors.
- `rsp_err`  out  1  qualified by `rsp_valid`: access fault or misaligned access.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - WAIT: counter runs from LATENCY down to 1.
  - RESP: `rsp_valid`=1.
- Transitions:
  - IDLE→WAIT on `req_valid` when LATENCY>0.
  - IDLE→RESP on `req_valid` when LATENCY=0.
  - WAIT→RESP when the counter equals 1.
  - RESP→IDLE always.
- Acceptance: on `req_valid & req_ready`, capture `addr`, `wstrb`, `wdata` and `funct3`. Input changes after acceptance have no effect.
- Word index is `addr[2 +: $clog2(DEPTH_WORDS)]`.
- Out of range: if `addr >= DEPTH_WORDS*4`, set `err`=1, perform no write, and return rdata 0.
- Write (`wstrb`≠0):
  - For each lane i with `wstrb[i]`, write `mem[idx][8i+7:8i] = wdata[8i+7:8i]`. Unstrobed lanes are unchanged.
  - `addr[1:0]` is ignored.
  - The commit happens on the clock edge entering RESP.
- Read (`wstrb`=0): the word is read on the edge entering RESP, then shifted right by `addr[1:0]*8`. Format by `funct3`:
  - 000 LB: sign-extend bit 7.
  - 100 LBU: zero-extend.
  - 001 LH: sign-extend bit 15; error if `addr[0]`=1.
  - 101 LHU: zero-extend; error if `addr[0]`=1.
  - 010 LW: error if `addr[1:0]`≠0.
  - 011, 110, 111: error.
- On any error, `rsp_rdata`=0 and memory is untouched.
- The response has no backpressure. The core is always waiting in its MEMREAD/MEMWRITE sequence, so `rsp_valid` is exactly one cycle.
- RAM contents are not reset or initialized by this block. Simulation preload via `$readmemh` is done by the bench.

## Timing
- Reset values: state IDLE, counter 0, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- A request accepted at edge N gives `rsp_valid` high during cycle N+1+LATENCY. `req_ready` is low from N+1 through the RESP cycle and returns to 1 at N+2+LATENCY.
- With LATENCY=0, the response comes the cycle after acceptance and throughput is one request per 2 cycles.
- `rsp_rdata`/`rsp_err` are registered. They are valid only while `rsp_valid`=1 and hold their value until the next response.
- `req_valid` held high through RESP: a new request is accepted only in the IDLE cycle that follows, with no double acceptance.
- Reset during WAIT: abort, return to IDLE, pending write not committed, no `rsp_valid`.
- Reset during the RESP cycle: `rsp_valid` deasserts at the next edge. The write was already committed.
- `reset` has priority over `req_valid` in the same cycle.

## Test plan
- Reset, then LATENCY=2, write `addr` 0x10, `wstrb` 1111, `wdata` 0xDEADBEEF → `rsp_valid` at N+3 with `err`=0. Then LW 0x10 → `rsp_rdata`=0xDEADBEEF, and `req_ready` is low for exactly 3 cycles.
- Byte stores: `wstrb` 0100, `wdata` 0x00AB0000 at 0x10 gives word 0xDEABBEEF. Then:
  - LB 0x12 → 0xFFFFFFAB.
  - LBU 0x12 → 0x000000AB.
  - LH 0x12 → 0xFFFFDEAB.
  - LHU 0x12 → 0x0000DEAB.
- Misaligned accesses → `err`=1, `rdata`=0:
  - LW at 0x11.
  - LH at 0x13.
  - `funct3`=011 at 0x10.

  A following LW 0x10 still returns 0xDEABBEEF.
- Out of range with DEPTH_WORDS=1024: write to 0x1000 gives `err`=1. An LW of the aliased address 0x0 returns the prior contents unchanged.
- Reset asserted in the second WAIT cycle of a write of 0x12345678 to 0x20 → no `rsp_valid`, `req_ready`=1 the next cycle, and LW 0x20 returns the old value.
- LATENCY=0, `req_valid` held high for 6 cycles with alternating addresses → exactly 3 `rsp_valid` pulses on every second cycle, with no missed or duplicate responses.
